// File: rtl/block_spawn_scheduler_pkg.sv
// Shared types and constants for the falling-block slot scheduler.
// Heights are in pixels; a slot is live from H_SPAWN up to H_BOTTOM-1.
package block_sched_pkg;

   localparam int DEF_NUM_LANES = 4;
   localparam int DEF_NUM_SLOTS = 8;
   localparam int DEF_BEAT_W    = 7;
   localparam int LANE_W        = $clog2(DEF_NUM_LANES);

   localparam logic [9:0] H_SPAWN  = 10'd120;
   localparam logic [9:0] H_BOTTOM = 10'd720;
   localparam logic [9:0] HIT_LO   = 10'd600;
   localparam logic [9:0] H_LAST   = H_BOTTOM - 10'd1;

   typedef logic [LANE_W-1:0] lane_t;

   typedef struct packed {
      logic       valid;
      lane_t      lane;
      logic [9:0] h;
   } slot_t;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      FROZEN = 1'b1
   } sched_state_e;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/block_spawn_scheduler_if.sv
// Chart/key inputs and renderer/judge outputs of the block scheduler.
// SCORE_EN adds the score and miss_cnt counters to the bundle.
interface block_spawn_scheduler_if #(
   parameter int NUM_LANES = 4,
   parameter int NUM_SLOTS = 8,
   parameter int BEAT_W    = 7,
   parameter int LANE_W    = $clog2(NUM_LANES)
);
   logic                        stop_or_endgame;
   logic [BEAT_W-1:0]           beat_cnt;
   logic [NUM_LANES-1:0]        chart_mask;
   logic [NUM_LANES-1:0]        hit_req;
   logic [NUM_SLOTS-1:0]        slot_valid;
   logic [NUM_SLOTS*LANE_W-1:0] slot_lane;
   logic [NUM_SLOTS*10-1:0]     slot_h;
   logic [NUM_LANES-1:0]        hit_ok;
   logic [NUM_LANES-1:0]        bad_hit;
   logic [NUM_LANES-1:0]        miss;
   logic                        overflow;
`ifdef SCORE_EN
   logic [15:0]                 score;
   logic [15:0]                 miss_cnt;
`endif

   modport master (
      output stop_or_endgame, beat_cnt, chart_mask, hit_req,
      input  slot_valid, slot_lane, slot_h, hit_ok, bad_hit, miss, overflow
`ifdef SCORE_EN
      , input score, miss_cnt
`endif
   );

   modport slave (
      input  stop_or_endgame, beat_cnt, chart_mask, hit_req,
      output slot_valid, slot_lane, slot_h, hit_ok, bad_hit, miss, overflow
`ifdef SCORE_EN
      , output score, miss_cnt
`endif
   );

endinterface

// File: rtl/block_spawn_scheduler_alloc.sv
// Find-first-free slot encoder; exclude masks slots already granted to
// lower lanes in the same cycle so a chain of these never double-books.
module slot_alloc_pe #(
   parameter int NUM_SLOTS = 8
) (
   input  logic                 enable,
   input  logic [NUM_SLOTS-1:0] busy,
   input  logic [NUM_SLOTS-1:0] exclude,
   output logic [NUM_SLOTS-1:0] grant,
   output logic                 found
);

   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise the
      // paths that skip an assignment would infer latches.
      grant = '0;
      found = 1'b0;
      if (enable) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !busy[i] && !exclude[i]) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/block_spawn_scheduler.sv
// Shared slot pool for falling note blocks: spawns on beat edges, moves one
// pixel per tick, retires on hit or bottom. Optional macro SCORE_EN adds counters.
module block_spawn_scheduler
   import block_sched_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int BEAT_W    = DEF_BEAT_W
) (
   input logic                    clk,
   input logic                    rst,
   input logic                    restart,
   block_spawn_scheduler_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_SLOTS);

   slot_t                slots [NUM_SLOTS];
   logic [BEAT_W-1:0]    pre_beat;
   sched_state_e         state, state_next;
   logic                 clear, run, beat_add;
   logic [NUM_LANES-1:0] hit_ok_q, bad_hit_q, miss_q;
   logic                 overflow_q;

   assign clear    = rst | restart;
   assign beat_add = bus.beat_cnt > pre_beat;

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (bus.stop_or_endgame)  state_next = FROZEN;
         FROZEN:  if (!bus.stop_or_endgame) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Freeze takes effect in the same cycle stop_or_endgame rises.
   assign run = (state_next == RUN);

   logic [NUM_SLOTS-1:0] busy;
   logic [NUM_SLOTS-1:0] excl  [NUM_LANES+1];
   logic [NUM_SLOTS-1:0] grant [NUM_LANES];
   logic [NUM_LANES-1:0] want, found;

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) busy[i] = slots[i].valid;
   end

   assign excl[0] = '0;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_alloc
      assign want[l] = run & beat_add & bus.chart_mask[l];

      slot_alloc_pe #(.NUM_SLOTS(NUM_SLOTS)) u_pe (
         .enable  (want[l]),
         .busy    (busy),
         .exclude (excl[l]),
         .grant   (grant[l]),
         .found   (found[l])
      );

      assign excl[l+1] = excl[l] | grant[l];
   end

   logic  [NUM_SLOTS-1:0] spawn;
   lane_t                 spawn_lane [NUM_SLOTS];

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         spawn[i]      = 1'b0;
         spawn_lane[i] = '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (grant[l][i]) begin
               spawn[i]      = 1'b1;
               spawn_lane[i] = lane_t'(l);
            end
         end
      end
   end

   // Per lane: pick the candidate deepest in the window, lowest index on a tie.
   logic [NUM_SLOTS-1:0] hit_free;
   logic [NUM_LANES-1:0] hit_found;
   logic [9:0]           best_h;
   logic [IDX_W-1:0]     best_idx;
   logic                 any;

   always_comb begin
      hit_free  = '0;
      hit_found = '0;
      best_h    = '0;
      best_idx  = '0;
      any       = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         best_h   = '0;
         best_idx = '0;
         any      = 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.hit_req[l] && slots[i].valid && slots[i].lane == lane_t'(l) &&
                slots[i].h >= HIT_LO && slots[i].h <= H_LAST &&
                (!any || slots[i].h > best_h)) begin
               any      = 1'b1;
               best_h   = slots[i].h;
               best_idx = IDX_W'(i);
            end
         end
         if (any) hit_free[best_idx] = 1'b1;
         hit_found[l] = any;
      end
   end

   logic [NUM_SLOTS-1:0] bottom;
   logic [NUM_LANES-1:0] miss_d;

   always_comb begin
      bottom = '0;
      miss_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slots[i].valid && run && slots[i].h == H_LAST && !hit_free[i]) begin
            bottom[i]             = 1'b1;
            miss_d[slots[i].lane] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (clear) begin
         // NOTE: the slot array is a handful of flops, not a RAM, so it is
         // reset like any other register.
         for (int i = 0; i < NUM_SLOTS; i++)
            slots[i] <= '{valid: 1'b0, lane: '0, h: H_SPAWN};
         pre_beat   <= '0;
         state      <= RUN;
         hit_ok_q   <= '0;
         bad_hit_q  <= '0;
         miss_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         pre_beat  <= bus.beat_cnt;
         state     <= state_next;
         hit_ok_q  <= bus.hit_req & hit_found;
         bad_hit_q <= bus.hit_req & ~hit_found;
         miss_q    <= miss_d;
         if (|(want & ~found)) overflow_q <= 1'b1;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_free[i] || bottom[i])
               slots[i] <= '{valid: 1'b0, lane: '0, h: H_SPAWN};
            else if (slots[i].valid) begin
               if (run) slots[i].h <= slots[i].h + 10'd1;
            end else if (spawn[i])
               slots[i] <= '{valid: 1'b1, lane: spawn_lane[i], h: H_SPAWN};
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         bus.slot_valid[i]                   = slots[i].valid;
         bus.slot_lane[i*LANE_W +: LANE_W]   = slots[i].lane;
         bus.slot_h[i*10 +: 10]              = slots[i].h;
      end
   end

   assign bus.hit_ok   = hit_ok_q;
   assign bus.bad_hit  = bad_hit_q;
   assign bus.miss     = miss_q;
   assign bus.overflow = overflow_q;

`ifdef SCORE_EN
   logic [15:0] score_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         score_q    <= '0;
         miss_cnt_q <= '0;
      end else begin
         score_q    <= sat_add16(score_q, 16'($countones(bus.hit_req & hit_found)));
         miss_cnt_q <= sat_add16(miss_cnt_q, 16'($countones(miss_d)));
      end
   end

   assign bus.score    = score_q;
   assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule
